cbus_arbiter_rr: RTL and testbench

Parametrised N-to-1 arbiter for the cache bus (CBus), placed between the per-core/per-cache CBus masters and the single memory-side CBus port. It selects one requester by fixed or round-robin priority and holds that grant until the slave signals `last`. It forwards the granted request and routes the response back to that requester only. An optional low-latency mode issues a request in the cycle it is selected, removing the one-cycle arbitration bubble.

---
 rtl/common.sv | 28 ++
 rtl/rr_picker.sv | 48 ++++
 rtl/cbus_arbiter_rr.sv | 124 ++++++++++++
 tb/tb_cbus_arbiter_rr.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// ---------------------------------------------------------------------------
// common
//   Shared CBus types for the cache-bus masters, slaves and arbiters.
//   cbus_req_t  : request bundle driven by a master toward a slave.
//   cbus_resp_t : response bundle driven by a slave back to a master.
//   arb_policy_t: arbitration policy selector for CBus arbiters.
//   arb_state_t : ownership state of a CBus arbiter.
// ---------------------------------------------------------------------------
package common;

    typedef enum logic {ARB_FIXED, ARB_ROUND_ROBIN} arb_policy_t;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Purely combinational requester picker used by the CBus arbiter.
//   Ports:
//     req   : one bit per requester, set when that requester is valid.
//     ptr   : index of the last completed owner (round-robin only).
//     found : at least one requester was selected.
//     sel   : index of the selected requester (0 when nothing is found).
//   FIXED picks the lowest set bit. ROUND_ROBIN picks the first set bit at
//   or above ptr+1, wrapping around.
// ---------------------------------------------------------------------------
module rr_picker
    import common::*;
#(
    parameter int          N      = 2,
    parameter arb_policy_t POLICY = ARB_ROUND_ROBIN,
    localparam int         IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] sel
);

    logic [2*N-1:0] dbl;
    int             start;

    // Doubled-mask priority encoder: the request vector is concatenated
    // with itself, bits below the start position are ignored, and the first
    // remaining set bit is taken. A hit in the upper copy is a wrapped
    // selection, so N is subtracted to fold it back into range.
    always_comb begin
        dbl   = {req, req};
        start = 0;
        if (POLICY == ARB_ROUND_ROBIN && N > 1) begin
            start = (int'(ptr) + 1) % N;
        end
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && i >= start && dbl[i]) begin
                found = 1'b1;
                sel   = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// cbus_arbiter_rr
//   N-to-1 CBus arbiter. Selects one master by fixed or round-robin
//   priority, holds the grant until the slave returns last, forwards the
//   owner's request and routes the slave response back to the owner only.
//   Ports:
//     clk, reset : clock and synchronous active-high reset.
//     ireqs      : requests from the masters.
//     iresps     : responses to the masters, zero except for the owner.
//     oreq       : request toward the slave.
//     oresp      : response from the slave (ready, last, data).
//     busy       : registered; a transaction is currently owned.
//     owner      : current owner, holds the previous owner while idle.
//   LOW_LATENCY=1 issues the selected request in the selection cycle
//   instead of one cycle later.
// ---------------------------------------------------------------------------
module cbus_arbiter_rr
    import common::*;
#(
    parameter int          NUM_INPUTS  = 2,
    parameter arb_policy_t POLICY      = ARB_ROUND_ROBIN,
    parameter int          LOW_LATENCY = 0,
    localparam int         IDX_W       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  cbus_req_t  [NUM_INPUTS-1:0] ireqs,
    output cbus_resp_t [NUM_INPUTS-1:0] iresps,
    output cbus_req_t                   oreq,
    input  cbus_resp_t                  oresp,
    output logic                        busy,
    output logic       [IDX_W-1:0]      owner
);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_INPUTS-1:0]  valid_mask;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_sel;

    // Collect the valid bits into a flat mask for the picker.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            valid_mask[i] = ireqs[i].valid;
        end
    end

    rr_picker #(
        .N      (NUM_INPUTS),
        .POLICY (POLICY)
    ) u_picker (
        .req   (valid_mask),
        .ptr   (ptr_q),
        .found (pick_found),
        .sel   (pick_sel)
    );

    // State, owner and round-robin pointer registers. The pointer resets to
    // the highest index so that input 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and output muxing. Selection only happens in IDLE, so a
    // completion and new requests in the same cycle are resolved with the
    // updated pointer in the following IDLE cycle. In low-latency mode a
    // single-beat transfer can finish in its selection cycle, in which case
    // the arbiter never leaves IDLE but still advances the pointer. Outputs
    // are forced to zero while reset is held so nothing issues mid-reset.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        oreq    = '0;
        iresps  = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_sel;
                    if (LOW_LATENCY != 0) begin
                        oreq             = ireqs[pick_sel];
                        iresps[pick_sel] = oresp;
                        if (oresp.last) begin
                            ptr_d = pick_sel;
                        end else begin
                            state_d = ARB_BUSY;
                        end
                    end else begin
                        state_d = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                oreq            = ireqs[owner_q];
                iresps[owner_q] = oresp;
                if (oresp.last) begin
                    state_d = ARB_IDLE;
                    ptr_d   = owner_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (reset) begin
            oreq   = '0;
            iresps = '0;
        end
    end

    assign busy  = (state_q == ARB_BUSY);
    assign owner = owner_q;

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_cbus_arbiter_rr
//   Self-checking bench for cbus_arbiter_rr. Three instances cover
//   round-robin (N=4), fixed priority (N=3) and low-latency round-robin
//   (N=4). Inputs change on the falling edge, outputs are compared 1 ns
//   later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_cbus_arbiter_rr;
    import common::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    cbus_req_t  [3:0] ireqs_a;
    cbus_resp_t [3:0] iresps_a;
    cbus_req_t        oreq_a;
    cbus_resp_t       oresp_a;
    logic             busy_a;
    logic [1:0]       owner_a;

    cbus_req_t  [2:0] ireqs_b;
    cbus_resp_t [2:0] iresps_b;
    cbus_req_t        oreq_b;
    cbus_resp_t       oresp_b;
    logic             busy_b;
    logic [1:0]       owner_b;

    cbus_req_t  [3:0] ireqs_c;
    cbus_resp_t [3:0] iresps_c;
    cbus_req_t        oreq_c;
    cbus_resp_t       oresp_c;
    logic             busy_c;
    logic [1:0]       owner_c;

    cbus_arbiter_rr #(.NUM_INPUTS(4), .POLICY(ARB_ROUND_ROBIN), .LOW_LATENCY(0)) dut_a (
        .clk(clk), .reset(reset), .ireqs(ireqs_a), .iresps(iresps_a),
        .oreq(oreq_a), .oresp(oresp_a), .busy(busy_a), .owner(owner_a));

    cbus_arbiter_rr #(.NUM_INPUTS(3), .POLICY(ARB_FIXED), .LOW_LATENCY(0)) dut_b (
        .clk(clk), .reset(reset), .ireqs(ireqs_b), .iresps(iresps_b),
        .oreq(oreq_b), .oresp(oresp_b), .busy(busy_b), .owner(owner_b));

    cbus_arbiter_rr #(.NUM_INPUTS(4), .POLICY(ARB_ROUND_ROBIN), .LOW_LATENCY(1)) dut_c (
        .clk(clk), .reset(reset), .ireqs(ireqs_c), .iresps(iresps_c),
        .oreq(oreq_c), .oresp(oresp_c), .busy(busy_c), .owner(owner_c));

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0] mask;
        logic       last;
        logic       exp_busy;
        logic [1:0] exp_owner;
    } vec_t;

    vec_t vecs [18];

    // Each master has a distinct, recognisable request so a forwarded
    // request identifies its source.
    function automatic cbus_req_t mk_req(input int i, input logic v);
        cbus_req_t r;
        r.valid = v;
        r.write = i[0];
        r.addr  = 32'h1000 * 32'(i + 1);
        r.wdata = 32'hC0DE_0000 + 32'(i);
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic last, input logic [31:0] data);
        cbus_resp_t r;
        r.ready = 1'b1;
        r.last  = last;
        r.data  = data;
        return r;
    endfunction

    // Drive one DUT's masters from a valid mask and its slave response.
    task automatic applyStimulus(input int dut, input logic [3:0] mask,
                                 input logic last, input logic [31:0] data);
        for (int i = 0; i < 4; i++) begin
            if (dut == 0) ireqs_a[i] = mk_req(i, mask[i]);
            if (dut == 2) ireqs_c[i] = mk_req(i, mask[i]);
            if (dut == 1 && i < 3) ireqs_b[i] = mk_req(i, mask[i]);
        end
        if (dut == 0) oresp_a = mk_resp(last, data);
        if (dut == 1) oresp_b = mk_resp(last, data);
        if (dut == 2) oresp_c = mk_resp(last, data);
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        cbus_resp_t       resp;
        cbus_resp_t [3:0] exp_r4;
        cbus_resp_t [2:0] exp_r3;
        cbus_req_t        exp_q;

        // Two-beat bursts from all four masters, then owner 0 drops valid
        // mid-burst while the others keep requesting.
        vecs[0]  = '{4'b1111, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{4'b1111, 1'b0, 1'b1, 2'd0};
        vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2'd0};
        vecs[3]  = '{4'b1111, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{4'b1111, 1'b0, 1'b1, 2'd1};
        vecs[5]  = '{4'b1111, 1'b1, 1'b1, 2'd1};
        vecs[6]  = '{4'b1111, 1'b0, 1'b0, 2'd1};
        vecs[7]  = '{4'b1111, 1'b0, 1'b1, 2'd2};
        vecs[8]  = '{4'b1111, 1'b1, 1'b1, 2'd2};
        vecs[9]  = '{4'b1111, 1'b0, 1'b0, 2'd2};
        vecs[10] = '{4'b1111, 1'b0, 1'b1, 2'd3};
        vecs[11] = '{4'b1111, 1'b1, 1'b1, 2'd3};
        vecs[12] = '{4'b1111, 1'b0, 1'b0, 2'd3};
        vecs[13] = '{4'b1111, 1'b0, 1'b1, 2'd0};
        vecs[14] = '{4'b1110, 1'b0, 1'b1, 2'd0};
        vecs[15] = '{4'b1110, 1'b1, 1'b1, 2'd0};
        vecs[16] = '{4'b1110, 1'b0, 1'b0, 2'd0};
        vecs[17] = '{4'b1110, 1'b0, 1'b1, 2'd1};

        applyStimulus(0, 4'b1111, 1'b0, 32'h0);
        applyStimulus(1, 4'b0000, 1'b0, 32'h0);
        applyStimulus(2, 4'b0000, 1'b0, 32'h0);

        // Reset held with every master requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_busy",  256'(busy_a),  256'(1'b0));
        checkOutput("reset_owner", 256'(owner_a), 256'(2'd0));
        checkOutput("reset_oreq",  256'(oreq_a),  256'(0));
        checkOutput("reset_iresp", 256'(iresps_a), 256'(0));

        // Round-robin table on dut_a.
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            reset = 1'b0;
            applyStimulus(0, vecs[r].mask, vecs[r].last, 32'hDA7A_0000 + 32'(r));
            resp   = mk_resp(vecs[r].last, 32'hDA7A_0000 + 32'(r));
            exp_q  = '0;
            exp_r4 = '0;
            if (vecs[r].exp_busy) begin
                exp_q = mk_req(int'(vecs[r].exp_owner), vecs[r].mask[vecs[r].exp_owner]);
                exp_r4[vecs[r].exp_owner] = resp;
            end
            #1;
            checkOutput($sformatf("row%0d_busy", r),   256'(busy_a),   256'(vecs[r].exp_busy));
            checkOutput($sformatf("row%0d_owner", r),  256'(owner_a),  256'(vecs[r].exp_owner));
            checkOutput($sformatf("row%0d_oreq", r),   256'(oreq_a),   256'(exp_q));
            checkOutput($sformatf("row%0d_iresps", r), 256'(iresps_a), 256'(exp_r4));
        end

        // Reset pulsed in the middle of a long burst owned by input 1.
        @(negedge clk);
        applyStimulus(0, 4'b1110, 1'b0, 32'h0000_0B02);
        #1;
        checkOutput("burst_busy",  256'(busy_a),  256'(1'b1));
        checkOutput("burst_owner", 256'(owner_a), 256'(2'd1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("in_reset_oreq", 256'(oreq_a), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 4'b1010, 1'b0, 32'h0);
        #1;
        checkOutput("post_rst_busy",  256'(busy_a),  256'(1'b0));
        checkOutput("post_rst_oreq",  256'(oreq_a),  256'(0));
        checkOutput("post_rst_owner", 256'(owner_a), 256'(2'd0));
        @(negedge clk);
        applyStimulus(0, 4'b1010, 1'b1, 32'h0);
        #1;
        checkOutput("post_rst_grant_busy",  256'(busy_a),  256'(1'b1));
        checkOutput("post_rst_grant_owner", 256'(owner_a), 256'(2'd1));
        checkOutput("post_rst_grant_oreq",  256'(oreq_a),  256'(mk_req(1, 1'b1)));
        @(negedge clk);
        applyStimulus(0, 4'b0000, 1'b0, 32'h0);

        // Fixed priority: masters 1 and 2 always requesting, 1 always wins.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            applyStimulus(1, 4'b0110, 1'b0, 32'h0);
            #1;
            checkOutput($sformatf("fix%0d_idle_busy", k), 256'(busy_b), 256'(1'b0));
            @(negedge clk);
            applyStimulus(1, 4'b0110, 1'b0, 32'hF000_0000 + 32'(k));
            #1;
            checkOutput($sformatf("fix%0d_owner", k), 256'(owner_b), 256'(2'd1));
            checkOutput($sformatf("fix%0d_oreq", k),  256'(oreq_b),  256'(mk_req(1, 1'b1)));
            @(negedge clk);
            applyStimulus(1, 4'b0110, 1'b1, 32'hF100_0000 + 32'(k));
            exp_r3    = '0;
            exp_r3[1] = mk_resp(1'b1, 32'hF100_0000 + 32'(k));
            #1;
            checkOutput($sformatf("fix%0d_last_busy", k), 256'(busy_b),   256'(1'b1));
            checkOutput($sformatf("fix%0d_iresps", k),    256'(iresps_b), 256'(exp_r3));
        end
        @(negedge clk);
        applyStimulus(1, 4'b0000, 1'b0, 32'h0);

        // Low latency: single-beat on input 2 completes in its selection cycle.
        applyStimulus(2, 4'b0100, 1'b1, 32'h5555_0002);
        exp_r4    = '0;
        exp_r4[2] = mk_resp(1'b1, 32'h5555_0002);
        #1;
        checkOutput("ll_issue_oreq",   256'(oreq_c),   256'(mk_req(2, 1'b1)));
        checkOutput("ll_issue_iresps", 256'(iresps_c), 256'(exp_r4));
        checkOutput("ll_issue_busy",   256'(busy_c),   256'(1'b0));
        @(negedge clk);
        applyStimulus(2, 4'b1101, 1'b0, 32'h0);
        #1;
        checkOutput("ll_next_busy",  256'(busy_c),  256'(1'b0));
        checkOutput("ll_next_owner", 256'(owner_c), 256'(2'd2));
        checkOutput("ll_next_oreq",  256'(oreq_c),  256'(mk_req(3, 1'b1)));
        @(negedge clk);
        applyStimulus(2, 4'b1101, 1'b1, 32'h5555_0003);
        exp_r4    = '0;
        exp_r4[3] = mk_resp(1'b1, 32'h5555_0003);
        #1;
        checkOutput("ll_busy_owner",  256'(owner_c),  256'(2'd3));
        checkOutput("ll_busy_busy",   256'(busy_c),   256'(1'b1));
        checkOutput("ll_busy_iresps", 256'(iresps_c), 256'(exp_r4));
        @(negedge clk);
        applyStimulus(2, 4'b0101, 1'b0, 32'h0);
        #1;
        checkOutput("ll_turn_busy", 256'(busy_c), 256'(1'b0));
        checkOutput("ll_turn_oreq", 256'(oreq_c), 256'(mk_req(0, 1'b1)));
        @(negedge clk);
        applyStimulus(2, 4'b0000, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
